// File: rtl/led_saxi_pwm.sv
// led_saxi_pwm: AXI4-Lite LED controller. NUM_CH channels share one prescaled PWM timebase;
// each channel runs off, on, PWM or blinking PWM from its own mode/duty/blink register.
module led_saxi_pwm #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 6,
  parameter int unsigned NUM_CH             = 4,
  parameter int unsigned PWM_BITS           = 8,
  parameter int unsigned PRESC_WIDTH        = 16
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [NUM_CH-1:0]               LED
);

  localparam int unsigned DataW = C_S_AXI_DATA_WIDTH;
  localparam int unsigned StrbW = DataW / 8;
  localparam int unsigned WordW = C_S_AXI_ADDR_WIDTH - 2;
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef logic [DataW-1:0] word_t;

  logic                            en_q;
  logic [PRESC_WIDTH-1:0]          presc_q, presc_cnt_q;
  logic [PWM_BITS-1:0]             pwm_cnt_q;
  logic [NUM_CH-1:0][PWM_BITS-1:0] duty_q, duty_act_q;
  logic [NUM_CH-1:0][1:0]          mode_q;
  logic [NUM_CH-1:0][7:0]          blink_q, blink_act_q, blink_cnt_q;
  logic [NUM_CH-1:0]               blink_state_q;
  logic [NUM_CH-1:0]               led_q, led_d;
  logic                            bvalid_q, rvalid_q;
  logic [1:0]                      bresp_q, rresp_q;
  word_t                           rdata_q;

  logic [WordW-1:0]  wr_word, rd_word;
  logic              wr_accept, rd_accept, wr_ok, wr_ctrl, wr_presc, rd_ok;
  logic [NUM_CH-1:0] wr_ch;
  word_t             wr_old, wr_merged, rd_data;
  logic              tick, frame_end;

  function automatic word_t ch_image(input logic [PWM_BITS-1:0] duty, input logic [1:0] mode,
                                     input logic [7:0] blink);
    word_t img;
    img = '0;
    img[PWM_BITS-1:0] = duty;
    img[9:8]          = mode;
    img[23:16]        = blink;
    return img;
  endfunction

  assign wr_word   = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign rd_word   = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign wr_accept = S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q & ~ARESET;
  assign rd_accept = S_AXI_ARVALID & ~rvalid_q & ~ARESET;

  assign S_AXI_AWREADY = wr_accept;
  assign S_AXI_WREADY  = wr_accept;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = rd_accept;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign LED           = led_q;

  // Merge byte lanes over the current register image so partial writes keep untouched fields.
  always_comb begin
    wr_ctrl  = (wr_word == WordW'(0));
    wr_presc = (wr_word == WordW'(1));
    wr_ok    = (wr_word < WordW'(4));
    wr_ch    = '0;
    wr_old   = '0;
    if (wr_ctrl)  wr_old = word_t'(en_q);
    if (wr_presc) wr_old = word_t'(presc_q);
    for (int k = 0; k < NUM_CH; k++) begin
      wr_ch[k] = (wr_word == WordW'(k + 4));
      if (wr_ch[k]) begin
        wr_ok  = 1'b1;
        wr_old = ch_image(duty_q[k], mode_q[k], blink_q[k]);
      end
    end
    wr_merged = wr_old;
    for (int b = 0; b < StrbW; b++) begin
      if (S_AXI_WSTRB[b]) wr_merged[8*b +: 8] = S_AXI_WDATA[8*b +: 8];
    end
  end

  always_comb begin
    rd_data = '0;
    rd_ok   = 1'b1;
    if (rd_word == WordW'(0))      rd_data = word_t'(en_q);
    else if (rd_word == WordW'(1)) rd_data = word_t'(presc_q);
    else if (rd_word == WordW'(2)) rd_data = word_t'(led_q);
    else if (rd_word != WordW'(3)) rd_ok = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (rd_word == WordW'(k + 4)) begin
        rd_ok   = 1'b1;
        rd_data = ch_image(duty_q[k], mode_q[k], blink_q[k]);
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      en_q    <= 1'b0;
      presc_q <= '0;
      duty_q  <= '0;
      mode_q  <= '0;
      blink_q <= '0;
    end else if (wr_accept) begin
      if (wr_ctrl)  en_q    <= wr_merged[0];
      if (wr_presc) presc_q <= wr_merged[PRESC_WIDTH-1:0];
      for (int k = 0; k < NUM_CH; k++) begin
        if (wr_ch[k]) begin
          duty_q[k]  <= wr_merged[PWM_BITS-1:0];
          mode_q[k]  <= wr_merged[9:8];
          blink_q[k] <= wr_merged[23:16];
        end
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      bvalid_q <= 1'b0;
      bresp_q  <= RespOkay;
    end else if (wr_accept) begin
      bvalid_q <= 1'b1;
      bresp_q  <= wr_ok ? RespOkay : RespSlvErr;
    end else if (S_AXI_BREADY) begin
      bvalid_q <= 1'b0;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rvalid_q <= 1'b0;
      rresp_q  <= RespOkay;
      rdata_q  <= '0;
    end else if (rd_accept) begin
      rvalid_q <= 1'b1;
      rresp_q  <= rd_ok ? RespOkay : RespSlvErr;
      rdata_q  <= rd_ok ? rd_data : '0;
    end else if (S_AXI_RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

  assign tick      = en_q & (presc_cnt_q == presc_q);
  assign frame_end = tick & (&pwm_cnt_q);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      presc_cnt_q <= '0;
      pwm_cnt_q   <= '0;
    end else if (!en_q) begin
      presc_cnt_q <= '0;
      pwm_cnt_q   <= '0;
    end else begin
      presc_cnt_q <= tick ? '0 : presc_cnt_q + 1'b1;
      if (tick) pwm_cnt_q <= pwm_cnt_q + 1'b1;
      // A new prescale value restarts the divider phase.
      if (wr_accept && wr_presc) presc_cnt_q <= '0;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      duty_act_q    <= '0;
      blink_act_q   <= '0;
      blink_cnt_q   <= '0;
      blink_state_q <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        // Static modes track the register directly; PWM modes switch only at frame boundaries.
        if (frame_end || !mode_q[k][1]) begin
          duty_act_q[k]  <= duty_q[k];
          blink_act_q[k] <= blink_q[k];
        end
        if (!en_q || blink_act_q[k] == 8'd0) begin
          blink_cnt_q[k]   <= 8'd0;
          blink_state_q[k] <= 1'b0;
        end else if (frame_end) begin
          if (8'(blink_cnt_q[k] + 8'd1) == blink_act_q[k]) begin
            blink_cnt_q[k]   <= 8'd0;
            blink_state_q[k] <= ~blink_state_q[k];
          end else begin
            blink_cnt_q[k] <= blink_cnt_q[k] + 8'd1;
          end
        end
      end
    end
  end

  always_comb begin
    led_d = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (en_q) begin
        unique case (mode_q[k])
          2'b00:   led_d[k] = 1'b0;
          2'b01:   led_d[k] = 1'b1;
          2'b10:   led_d[k] = (pwm_cnt_q < duty_act_q[k]);
          default: led_d[k] = blink_state_q[k] & (pwm_cnt_q < duty_act_q[k]);
        endcase
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) led_q <= '0;
    else        led_q <= led_d;
  end

  logic unused_bits;
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                         wr_merged};

endmodule
